// File: rtl/ee354_move_request.sv
// rtl/ee354_move_request.sv - debounced one-hot move request initiator for the 2048 game FSM (optional MOVE_REPEAT_EN)
module ee354_move_request #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18,
   parameter int REPEAT_CYCLES   = 200000
) (
   input  logic Clk,
   input  logic Reset,
   input  logic btn_up,
   input  logic btn_down,
   input  logic btn_left,
   input  logic btn_right,
   input  logic q_Wait,
   output logic up,
   output logic down,
   output logic left,
   output logic right,
   output logic busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // The counters must be able to reach their terminal counts.
   if ((longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_W)) ||
       (longint'(REPEAT_CYCLES) > (longint'(1) << CNT_W))) begin : g_cnt_w_check
      $error("CNT_W too narrow for DEBOUNCE_CYCLES/REPEAT_CYCLES");
   end

   // Button vectors are ordered {up, down, left, right}; bit 3 has top priority.
   logic [3:0]       raw;
   logic [3:0]       sync1;
   logic [3:0]       sync2;
   logic [3:0]       stable;
   logic [3:0]       stable_d;
   logic [3:0]       press;
   logic [3:0]       win;
   logic [CNT_W-1:0] deb_cnt [4];
   state_t           state;
   state_t           state_nxt;
   logic [3:0]       dir;
   logic [3:0]       dir_nxt;
   logic [3:0]       move_q;
   logic             busy_q;

`ifdef MOVE_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
   logic [CNT_W-1:0] rep_cnt;
   logic [CNT_W-1:0] rep_cnt_nxt;
`endif

   assign raw   = {btn_up, btn_down, btn_left, btn_right};
   assign press = stable & ~stable_d;

   // Two-flop synchronizer for the asynchronous raw buttons.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Per-button debounce: stable follows sync2 only after it has differed for DEBOUNCE_CYCLES cycles.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
         stable   <= '0;
         stable_d <= '0;
      end else begin
         stable_d <= stable;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == stable[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               stable[i]  <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Priority pick among simultaneous press events; losers are discarded.
   always_comb begin
      win = '0;
      if (press[3])      win = 4'b1000;
      else if (press[2]) win = 4'b0100;
      else if (press[1]) win = 4'b0010;
      else if (press[0]) win = 4'b0001;
   end

   // Next-state logic: one request per press, held until accepted, then wait for full release.
   always_comb begin
      state_nxt = state;
      dir_nxt   = dir;
`ifdef MOVE_REPEAT_EN
      rep_cnt_nxt = '0;
`endif
      case (state)
         IDLE: begin
            if (press != 4'b0000) begin
               state_nxt = REQ;
               dir_nxt   = win;
            end
         end
         REQ: begin
            if (q_Wait) state_nxt = RELEASE;
         end
         RELEASE: begin
            if (stable == 4'b0000) begin
               state_nxt = IDLE;
               dir_nxt   = '0;
            end
`ifdef MOVE_REPEAT_EN
            else if (stable == dir) begin
               if (rep_cnt == REP_LAST) state_nxt = REQ;
               else                     rep_cnt_nxt = rep_cnt + 1'b1;
            end
`endif
         end
         default: begin
            state_nxt = IDLE;
            dir_nxt   = '0;
         end
      endcase
   end

   // State register with registered outputs so the request lines never glitch.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state  <= IDLE;
         dir    <= '0;
         move_q <= '0;
         busy_q <= 1'b0;
`ifdef MOVE_REPEAT_EN
         rep_cnt <= '0;
`endif
      end else begin
         state  <= state_nxt;
         dir    <= dir_nxt;
         move_q <= (state_nxt == REQ) ? dir_nxt : 4'b0000;
         busy_q <= (state_nxt != IDLE);
`ifdef MOVE_REPEAT_EN
         rep_cnt <= rep_cnt_nxt;
`endif
      end
   end

   assign {up, down, left, right} = move_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_ee354_move_request.sv
// tb/tb_ee354_move_request.sv - table, directed and randomized checks of ee354_move_request
module tb_ee354_move_request;

   localparam int DEB = 4;
   localparam int REP = 8;

   logic Clk = 1'b0;
   logic Reset = 1'b0;
   logic btn_up = 1'b0;
   logic btn_down = 1'b0;
   logic btn_left = 1'b0;
   logic btn_right = 1'b0;
   logic q_Wait = 1'b1;
   logic up, down, left, right, busy;

   int checks = 0;
   int errors = 0;

   ee354_move_request #(
      .DEBOUNCE_CYCLES(DEB),
      .CNT_W(18),
      .REPEAT_CYCLES(REP)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .btn_up(btn_up),
      .btn_down(btn_down),
      .btn_left(btn_left),
      .btn_right(btn_right),
      .q_Wait(q_Wait),
      .up(up),
      .down(down),
      .left(left),
      .right(right),
      .busy(busy)
   );

   always #5 Clk = ~Clk;

   // Reference model: raw history window for debouncing, request/release bookkeeping for the FSM.
   logic [3:0] hist [DEB+2];
   logic [3:0] m_stable;
   logic [3:0] m_stable_prev;
   int         m_req;
   bit         m_releasing;
   int         m_dir;
   int         m_rc;

   task automatic model_reset();
      for (int i = 0; i < DEB + 2; i++) hist[i] = 4'b0000;
      m_stable      = 4'b0000;
      m_stable_prev = 4'b0000;
      m_req         = -1;
      m_releasing   = 1'b0;
      m_dir         = 0;
      m_rc          = 0;
   endtask

   task automatic model_step(input logic [3:0] raw, input logic qw);
      logic [3:0] rises;
      logic [3:0] dir_mask;
      rises = m_stable & ~m_stable_prev;
      dir_mask = 4'b0000;
      dir_mask[m_dir] = 1'b1;
      if (m_req >= 0) begin
         if (qw) begin
            m_dir       = m_req;
            m_req       = -1;
            m_releasing = 1'b1;
            m_rc        = 0;
         end
      end else if (m_releasing) begin
         if (m_stable == 4'b0000) begin
            m_releasing = 1'b0;
         end
`ifdef MOVE_REPEAT_EN
         else if (m_stable == dir_mask) begin
            if (m_rc == REP - 1) begin
               m_req       = m_dir;
               m_releasing = 1'b0;
               m_rc        = 0;
            end else begin
               m_rc++;
            end
         end else begin
            m_rc = 0;
         end
`endif
      end else if (rises != 4'b0000) begin
         for (int b = 0; b < 4; b++) if (rises[b]) m_req = b;
      end
      for (int i = DEB + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = raw;
      m_stable_prev = m_stable;
      for (int b = 0; b < 4; b++) begin
         bit all_differ;
         all_differ = 1'b1;
         for (int j = 2; j < DEB + 2; j++) if (hist[j][b] == m_stable[b]) all_differ = 1'b0;
         if (all_differ) m_stable[b] = ~m_stable[b];
      end
   endtask

   function automatic logic [4:0] model_out();
      logic [3:0] mv;
      mv = 4'b0000;
      if (m_req >= 0) mv[m_req] = 1'b1;
      return {mv, (m_req >= 0) || m_releasing};
   endfunction

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got {u,d,l,r,busy}=%b expected %b", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      if (Reset) model_step({btn_up, btn_down, btn_left, btn_right}, q_Wait);
      else       model_reset();
      @(negedge Clk);
      check($sformatf("model@%0t", $time), {up, down, left, right, busy}, model_out());
   endtask

   typedef struct {
      bit         rst_n;
      logic [3:0] btn;
      bit         qw;
      int         cycles;
      logic [3:0] exp_mv;
      bit         exp_busy;
   } vec_t;

   vec_t tbl[$];
   int   pulses[$];
   int   exp_pulses[$];

   initial begin
      // Reset press-through, wait-state hold/accept, simultaneous press priority.
      tbl.push_back('{1'b0, 4'b1000, 1'b1, 3, 4'b0000, 1'b0});
      tbl.push_back('{1'b1, 4'b1000, 1'b1, 6, 4'b0000, 1'b0});
      tbl.push_back('{1'b1, 4'b1000, 1'b1, 1, 4'b1000, 1'b1});
      tbl.push_back('{1'b1, 4'b1000, 1'b1, 1, 4'b0000, 1'b1});
      tbl.push_back('{1'b1, 4'b0000, 1'b1, 6, 4'b0000, 1'b1});
      tbl.push_back('{1'b1, 4'b0000, 1'b1, 1, 4'b0000, 1'b0});
      tbl.push_back('{1'b1, 4'b0100, 1'b0, 7, 4'b0100, 1'b1});
      tbl.push_back('{1'b1, 4'b0100, 1'b0, 5, 4'b0100, 1'b1});
      tbl.push_back('{1'b1, 4'b0100, 1'b1, 1, 4'b0000, 1'b1});
      tbl.push_back('{1'b1, 4'b0100, 1'b0, 1, 4'b0000, 1'b1});
      tbl.push_back('{1'b1, 4'b0000, 1'b0, 6, 4'b0000, 1'b1});
      tbl.push_back('{1'b1, 4'b0000, 1'b0, 1, 4'b0000, 1'b0});
      tbl.push_back('{1'b1, 4'b1001, 1'b1, 7, 4'b1000, 1'b1});
      tbl.push_back('{1'b1, 4'b1001, 1'b1, 1, 4'b0000, 1'b1});
      tbl.push_back('{1'b1, 4'b0001, 1'b1, 10, 4'b0000, 1'b1});
      tbl.push_back('{1'b1, 4'b0000, 1'b1, 6, 4'b0000, 1'b1});
      tbl.push_back('{1'b1, 4'b0000, 1'b1, 1, 4'b0000, 1'b0});
      tbl.push_back('{1'b1, 4'b0001, 1'b1, 6, 4'b0000, 1'b0});
      tbl.push_back('{1'b1, 4'b0001, 1'b1, 1, 4'b0001, 1'b1});
      tbl.push_back('{1'b1, 4'b0001, 1'b1, 1, 4'b0000, 1'b1});
      tbl.push_back('{1'b1, 4'b0000, 1'b1, 7, 4'b0000, 1'b0});

      model_reset();
      @(negedge Clk);
      check("reset_state", {up, down, left, right, busy}, 5'b00000);
      tick();

      foreach (tbl[i]) begin
         Reset = tbl[i].rst_n;
         if (!Reset) model_reset();
         {btn_up, btn_down, btn_left, btn_right} = tbl[i].btn;
         q_Wait = tbl[i].qw;
         repeat (tbl[i].cycles) tick();
         check($sformatf("vec%0d", i), {up, down, left, right, busy}, {tbl[i].exp_mv, tbl[i].exp_busy});
      end

      // Bounce on left shorter than the debounce window never becomes a request.
      q_Wait = 1'b1;
      for (int k = 0; k < 20; k++) begin
         btn_left = ((k / 2) % 2 == 0);
         tick();
         check("bounce_left", {left, busy}, 5'b00000);
      end
      btn_left = 1'b0;
      repeat (10) begin
         tick();
         check("bounce_left_after", {left, busy}, 5'b00000);
      end

      // Asynchronous reset while a request is held in REQ.
      q_Wait = 1'b0;
      btn_down = 1'b1;
      repeat (7) tick();
      check("held_down", {up, down, left, right, busy}, 5'b01001);
      #2;
      Reset = 1'b0;
      btn_down = 1'b0;
      model_reset();
      #1;
      check("async_reset", {up, down, left, right, busy}, 5'b00000);
      @(negedge Clk);
      Reset = 1'b1;
      q_Wait = 1'b1;
      repeat (20) begin
         tick();
         check("post_reset_quiet", {up, down, left, right, busy}, 5'b00000);
      end

      // Held up for 40 cycles: one pulse, or periodic pulses with auto-repeat.
      btn_up = 1'b1;
      for (int t = 1; t <= 40; t++) begin
         tick();
         if (up) pulses.push_back(t);
      end
`ifdef MOVE_REPEAT_EN
      exp_pulses = '{7, 16, 25, 34};
`else
      exp_pulses = '{7};
`endif
      checks++;
      if (pulses.size() != exp_pulses.size()) begin
         errors++;
         $display("FAIL hold_up_count: got %0d pulses expected %0d", pulses.size(), exp_pulses.size());
      end else begin
         foreach (exp_pulses[i]) begin
            checks++;
            if (pulses[i] != exp_pulses[i]) begin
               errors++;
               $display("FAIL hold_up_cycle%0d: got %0d expected %0d", i, pulses[i], exp_pulses[i]);
            end
         end
      end
      btn_up = 1'b0;
      repeat (16) tick();

      // Randomized buttons, wait handshakes and occasional resets against the model.
      for (int s = 0; s < 250; s++) begin
         int         r;
         int         hold;
         logic [3:0] b;
         r = $urandom_range(0, 99);
         if (r < 3) begin
            Reset = 1'b0;
            model_reset();
            tick();
            tick();
            Reset = 1'b1;
         end
         r = $urandom_range(0, 99);
         if (r < 40)      b = 4'b0000;
         else if (r < 80) b = 4'(1 << $urandom_range(0, 3));
         else             b = 4'($urandom_range(0, 15));
         {btn_up, btn_down, btn_left, btn_right} = b;
         hold = $urandom_range(1, 14);
         repeat (hold) begin
            q_Wait = ($urandom_range(0, 3) != 0);
            tick();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
